stopwatch_ctrl: RTL and testbench

//  Controller that sequences a chain of cascaded decade (BCD) counters as a stopwatch.
//  - Prescaler divides clk into count ticks.
//  - Start/stop/clear FSM gates the prescaler and digit chain.
//  - Ripples carries between digits; flags overflow.
//  - Sits between board buttons (already debounced to one-cycle pulses) and a 7-segment display driver.

---
 rtl/stopwatch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaler, start/stop/clear FSM and a BCD digit chain.
// Optional lap hold is compiled in with STOPWATCH_LAP_EN.
//
// Parameters:
//   TICK_DIV   clk cycles per count tick (>= 1)
//   DIGITS     number of BCD digits (1..8)
// Ports:
//   clk        system clock, posedge
//   rst        synchronous active-high reset
//   i_start    pulse: start or resume counting
//   i_stop     pulse: pause counting
//   i_clear    pulse: zero count, prescaler, overflow and hold; go IDLE
//   i_lap      pulse: toggle lap hold (STOPWATCH_LAP_EN only)
//   o_bcd      displayed count, digit 0 in [3:0]
//   o_running  high while the FSM is in RUN
//   o_tick     one-cycle pulse when a new count becomes visible
//   o_ovf      sticky flag: chain wrapped from all 9s to all 0s
//   o_hold     high while lap hold is active
module stopwatch_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int DIGITS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_clear,
    input  logic                i_lap,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic                o_running,
    output logic                o_tick,
    output logic                o_ovf,
    output logic                o_hold
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [PW-1:0]       presc;
    logic [PW-1:0]       presc_nx;
    logic                tick_nx;
    logic [4*DIGITS-1:0] count;
    logic [4*DIGITS-1:0] count_nx;
    logic [DIGITS:0]     carry;
    logic                wrap;
    logic                tick_q;
    logic                ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Stop outranks the tick: a stop on the terminal prescaler value
    // leaves the prescaler parked there, so resume ticks next cycle.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        tick_nx  = 1'b0;
        if (i_clear) begin
            state_nx = IDLE;
            presc_nx = '0;
        end else begin
            case (state)
                RUN: begin
                    if (i_stop) begin
                        state_nx = PAUSE;
                    end else if (presc == PMAX) begin
                        presc_nx = '0;
                        tick_nx  = 1'b1;
                    end else begin
                        presc_nx = presc + 1'b1;
                    end
                end
                IDLE, PAUSE: begin
                    if (i_start && !i_stop) begin
                        state_nx = RUN;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Single-cycle ripple: each digit passes a carry on when it wraps.
    always_comb begin
        count_nx = count;
        carry    = '0;
        carry[0] = tick_nx;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry[i]) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_nx[4*i +: 4] = 4'd0;
                    carry[i+1]         = 1'b1;
                end else begin
                    count_nx[4*i +: 4] = count[4*i +: 4] + 4'd1;
                end
            end
        end
        wrap = carry[DIGITS];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            count  <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (i_clear) begin
            presc  <= '0;
            count  <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            presc  <= presc_nx;
            count  <= count_nx;
            tick_q <= tick_nx;
            ovf_q  <= ovf_q | wrap;
        end
    end

    assign o_running = (state == RUN);
    assign o_tick    = tick_q;
    assign o_ovf     = ovf_q;

`ifdef STOPWATCH_LAP_EN
    logic [4*DIGITS-1:0] lap;
    logic                hold;

    // The snapshot takes the count visible before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap  <= '0;
            hold <= 1'b0;
        end else if (i_clear) begin
            hold <= 1'b0;
        end else if (i_lap && state != IDLE) begin
            if (!hold) begin
                lap <= count;
            end
            hold <= !hold;
        end
    end

    assign o_hold = hold;
    assign o_bcd  = hold ? lap : count;
`else
    logic unused_lap;
    assign unused_lap = i_lap;
    assign o_hold     = 1'b0;
    assign o_bcd      = count;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random pulses,
// all compared against an integer-count reference model.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DIGITS   = 2;
    localparam int MAXC     = 100;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_start;
    logic                i_stop;
    logic                i_clear;
    logic                i_lap;
    logic [4*DIGITS-1:0] o_bcd;
    logic                o_running;
    logic                o_tick;
    logic                o_ovf;
    logic                o_hold;

    int errors = 0;
    int checks = 0;

    int m_mode;
    int m_phase;
    int m_count;
    int m_snap;
    bit m_ovf;
    bit m_hold;
    bit m_tick;

    stopwatch_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DIGITS  (DIGITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_stop   (i_stop),
        .i_clear  (i_clear),
        .i_lap    (i_lap),
        .o_bcd    (o_bcd),
        .o_running(o_running),
        .o_tick   (o_tick),
        .o_ovf    (o_ovf),
        .o_hold   (o_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int n);
        logic [31:0] v;
        int          r;
        v = '0;
        r = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return v;
    endfunction

    task automatic model_step();
        m_tick = 1'b0;
        if (rst || i_clear) begin
            m_mode  = M_IDLE;
            m_phase = 0;
            m_count = 0;
            m_ovf   = 1'b0;
            m_hold  = 1'b0;
            if (rst) m_snap = 0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (i_lap && m_mode != M_IDLE) begin
                if (!m_hold) m_snap = m_count;
                m_hold = !m_hold;
            end
`endif
            if (m_mode == M_RUN) begin
                if (i_stop) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_phase++;
                    if (m_phase == TICK_DIV) begin
                        m_phase = 0;
                        m_tick  = 1'b1;
                        m_count = m_count + 1;
                        if (m_count == MAXC) begin
                            m_count = 0;
                            m_ovf   = 1'b1;
                        end
                    end
                end
            end else if (i_start && !i_stop) begin
                m_mode = M_RUN;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("bcd", 32'(o_bcd), to_bcd(m_hold ? m_snap : m_count));
        check("running", 32'(o_running), 32'(m_mode == M_RUN));
        check("tick", 32'(o_tick), 32'(m_tick));
        check("ovf", 32'(o_ovf), 32'(m_ovf));
        check("hold", 32'(o_hold), 32'(m_hold));
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_clear = 1'b0;
        i_lap   = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_clear = 1'b0;
        i_lap   = 1'b0;
        m_snap  = 0;
        repeat (3) cycle();
        check("rst_bcd", 32'(o_bcd), 32'h0);
        check("rst_run", 32'(o_running), 32'h0);
        rst = 1'b0;

        // first count TICK_DIV cycles after the start edge
        i_start = 1'b1;
        cycle();
        check("t1_run", 32'(o_running), 32'h1);
        repeat (3) cycle();
        check("t1_pre", 32'(o_bcd), 32'h00);
        cycle();
        check("t1_bcd1", 32'(o_bcd), 32'h01);
        check("t1_tick1", 32'(o_tick), 32'h1);
        cycle();
        check("t1_tick0", 32'(o_tick), 32'h0);
        repeat (3) cycle();
        check("t1_bcd2", 32'(o_bcd), 32'h02);

        // stop on the tick edge that would give 06
        repeat (15) cycle();
        check("t4_pre", 32'(o_bcd), 32'h05);
        i_stop = 1'b1;
        cycle();
        check("t4_hold", 32'(o_bcd), 32'h05);
        check("t4_notick", 32'(o_tick), 32'h0);
        repeat (3) cycle();
        i_start = 1'b1;
        cycle();
        check("t4_resume", 32'(o_bcd), 32'h05);
        cycle();
        check("t4_bcd6", 32'(o_bcd), 32'h06);
        check("t4_tick", 32'(o_tick), 32'h1);

        // wrap and sticky overflow
        i_clear = 1'b1;
        cycle();
        i_start = 1'b1;
        cycle();
        repeat (399) cycle();
        check("t2_99", 32'(o_bcd), 32'h99);
        cycle();
        check("t2_wrap", 32'(o_bcd), 32'h00);
        check("t2_ovf", 32'(o_ovf), 32'h1);
        repeat (40) cycle();
        check("t2_ovf10", 32'(o_ovf), 32'h1);
        check("t2_bcd10", 32'(o_bcd), 32'h10);
        repeat (108) cycle();
        check("t5_37", 32'(o_bcd), 32'h37);

        // clear beats start on the same edge
        i_clear = 1'b1;
        i_start = 1'b1;
        cycle();
        check("t5_bcd", 32'(o_bcd), 32'h0);
        check("t5_ovf", 32'(o_ovf), 32'h0);
        check("t5_run", 32'(o_running), 32'h0);

        // reset mid-run
        i_start = 1'b1;
        cycle();
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5_rst_bcd", 32'(o_bcd), 32'h0);
        check("t5_rst_run", 32'(o_running), 32'h0);

        // lap hold
        i_start = 1'b1;
        cycle();
        repeat (20) cycle();
        check("t6_05", 32'(o_bcd), 32'h05);
        i_lap = 1'b1;
        cycle();
        repeat (11) cycle();
`ifdef STOPWATCH_LAP_EN
        check("t6_snap", 32'(o_bcd), 32'h05);
        check("t6_hold", 32'(o_hold), 32'h1);
`else
        check("t6_live", 32'(o_bcd), 32'h08);
        check("t6_hold", 32'(o_hold), 32'h0);
`endif
        i_lap = 1'b1;
        cycle();
        check("t6_back", 32'(o_bcd), 32'h08);
        check("t6_hold0", 32'(o_hold), 32'h0);

        // random pulses
        for (int n = 0; n < 6000; n++) begin
            int r;
            r       = int'($urandom_range(0, 1999));
            rst     = (r == 0);
            i_clear = (r >= 1 && r <= 3);
            i_start = ($urandom_range(0, 9) == 0);
            i_stop  = ($urandom_range(0, 199) == 0);
            if (i_stop) i_start = 1'b0;
            i_lap   = ($urandom_range(0, 39) == 0);
            cycle();
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
